denormalize: RTL
================

Name: denormalize

Overview:
- Inverse of the vector normaliser. Takes a unit direction (nx, ny, nz) and a magnitude (length) in signed fixed point, and rebuilds the vector x = nx*length, y = ny*length, z = nz*length.
- Uses one shared sequential shift-add multiplier. The three components are processed one after another, so area stays small for the billiard physics path (velocity rebuild after a collision).
- Start/done handshake. Results are registered.

Parameters:
- WIDTH, 32, total bit width of every signed fixed-point operand and result.
- FRAC_WIDTH, 30, fractional bits (default format Q2.30, 1.0 = 0x40000000).
- EPS, 1024, magnitude threshold used only by DENORM_ZERO_BYPASS_EN.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- nx, ny, nz  input  WIDTH  signed unit-direction components; captured when start is accepted.
- length  input  WIDTH  signed magnitude; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- x, y, z  output  WIDTH  signed results; held until the next done.
- overflow  output  1  set if any component of the last operation saturated; updated at done.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE; x, y, z, overflow, busy and done all go to 0. An operation in flight is discarded and produces no done.
- States: IDLE, MUL, FIN, DONE.
- IDLE -> MUL:
  - Taken when start=1 in IDLE.
  - Captures the inputs, the magnitudes |n_c| and |length| (unsigned WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1)), and the sign n_c XOR length.
  - Clears the 2*WIDTH-bit accumulator. Component index c starts at x.
- MUL:
  - Runs WIDTH cycles. Each cycle tests one bit of |length|, LSB first; if the bit is set, |n_c| shifted left by the bit index is added to the accumulator.
  - Then goes to FIN.
- FIN (1 cycle):
  - mag = acc >> FRAC_WIDTH (truncate the magnitude, i.e. round toward zero).
  - Apply the sign.
  - Saturate: if mag exceeds the signed range, output 2^(WIDTH-1)-1 for a positive result or -2^(WIDTH-1) for a negative result, and set the sticky overflow bit for this operation.
  - Write the component register. If c < z, advance c, reload the operand magnitude and sign, clear the accumulator, and return to MUL. Otherwise go to DONE.
- DONE: done=1 and busy=0 for one cycle; overflow output is updated; return to IDLE.
- Latency: if start is accepted at cycle T, done is high at cycle T + 3*(WIDTH+1) + 1. That is cycle T+100 at the default WIDTH.
- start while busy or while done is high: ignored, with no queueing.
- start can be accepted again in the cycle after done.
- x, y, z are updated one at a time as each FIN completes. Consumers must sample them only at or after done.
- A zero length or zero component gives an exact 0.
- Multiplying by exactly 1.0 returns the other operand unchanged.

Optional Feature:
- Macro DENORM_ZERO_BYPASS_EN.
- When defined: if |length| < EPS at acceptance, the FSM goes from IDLE straight to DONE. x, y, z and overflow are written 0 on that edge, and done is high at cycle T+1.
- When not defined: no comparison logic is built. Small lengths take the full multiply path and the full latency.

Decomposition:
- Package denorm_pkg:
  - state enum (IDLE, MUL, FIN, DONE);
  - component index enum;
  - Q-format constants ONE, SAT_MAX, SAT_MIN;
  - counter width, $clog2(WIDTH).
- Sub-module seq_fix_mult: a one-component sign-magnitude shift-add multiplier.
  - Handshake: load/valid, WIDTH+1 cycles per product, saturating result plus sat flag.
  - The top level sequences it three times.

Test Plan:
- Basic scaling: n=(0x40000000,0,0), length=0x20000000, start at T -> done at T+100; x=0x20000000, y=z=0; overflow=0.
- Unit length passes direction through: n=(0x26666666,0xCCCCCCCD,0), length=0x40000000 -> x=0x26666666, y=0xCCCCCCCD, z=0.
- Negative length: n=(0x20000000,0xE0000000,0x40000000), length=0xC0000000 -> x=0xE0000000, y=0x20000000, z=0xC0000000.
- Saturation: n=(0x60000000,0xA0000000,0), length=0x60000000 -> x=0x7FFFFFFF, y=0x80000000, z=0; overflow=1.
- Handshake and reset:
  - start pulsed at T+10 while busy -> ignored, single done at T+100.
  - rst asserted at T+50 -> outputs 0 immediately, no done.
  - new start after reset -> done 100 cycles later.
- With DENORM_ZERO_BYPASS_EN: length=0x00000100 -> done at T+1, x=y=z=0.
- Without DENORM_ZERO_BYPASS_EN: length=0x00000100 -> done at T+100 with truncated products.

Source files
------------

// File: rtl/denorm_pkg.sv
// Shared types and Q-format constants for the denormalize datapath.
package denorm_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_FRAC  = 30;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  localparam logic [DEF_WIDTH-1:0] ONE     = 32'h4000_0000;
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;
  typedef enum logic [1:0] {COMP_X, COMP_Y, COMP_Z} comp_t;

endpackage

// File: rtl/denormalize_mult.sv
// Sign-magnitude shift-add multiplier: load, WIDTH accumulate cycles, then one
// cycle with a valid, saturated fixed-point product.
module seq_fix_mult
  import denorm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic                    o_last,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_result,
  output logic                    o_sat
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] MAG_POS = {{WIDTH{1'b0}}, POS_LIM};
  localparam logic [2*WIDTH-1:0] MAG_NEG = {{WIDTH{1'b0}}, NEG_LIM};

  logic [2*WIDTH-1:0] r_acc, r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [CW-1:0]      r_cnt;
  logic               r_neg, r_run, r_fin;

  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_low;
  logic [2*WIDTH-1:0] w_shift;

  // Most negative input maps to 2^(WIDTH-1) as an unsigned magnitude.
  assign w_a_mag = i_a[WIDTH-1] ? WIDTH'(-i_a) : WIDTH'(i_a);
  assign w_b_mag = i_b[WIDTH-1] ? WIDTH'(-i_b) : WIDTH'(i_b);

  assign o_last  = r_run && (r_cnt == CW'(WIDTH-1));
  assign o_valid = r_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_run  <= 1'b0;
      r_fin  <= 1'b0;
    end else if (i_load) begin
      r_acc  <= '0;
      r_a_sh <= {{WIDTH{1'b0}}, w_a_mag};
      r_b_sh <= w_b_mag;
      r_cnt  <= '0;
      r_neg  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_run  <= 1'b1;
      r_fin  <= 1'b0;
    end else if (r_run) begin
      if (r_b_sh[0]) r_acc <= r_acc + r_a_sh;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= r_cnt + 1'b1;
      if (o_last) begin
        r_run <= 1'b0;
        r_fin <= 1'b1;
      end
    end else begin
      r_fin <= 1'b0;
    end
  end

  assign w_shift = r_acc >> FRAC_WIDTH;
  assign w_low   = w_shift[WIDTH-1:0];

  always_comb begin
    o_sat    = r_neg ? (w_shift > MAG_NEG) : (w_shift > MAG_POS);
    o_result = r_neg ? -w_low : w_low;
    if (o_sat) o_result = r_neg ? NEG_LIM : POS_LIM;
  end

endmodule

// File: rtl/denormalize.sv
// Rebuilds (x,y,z) = n*length with one shared sequential multiplier.
// Optional DENORM_ZERO_BYPASS_EN: lengths with |length| < EPS finish at once with zeros.
module denormalize
  import denorm_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30
`ifdef DENORM_ZERO_BYPASS_EN
  , parameter int EPS      = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] nx,
  input  logic signed [WIDTH-1:0] ny,
  input  logic signed [WIDTH-1:0] nz,
  input  logic signed [WIDTH-1:0] length,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] z,
  output logic                    overflow
);

  state_t                  r_state;
  comp_t                   r_comp;
  logic signed [WIDTH-1:0] r_ny, r_nz, r_len, r_x, r_y, r_z;
  logic                    r_busy, r_done, r_ovf, r_sticky;

  logic                    w_load, w_last, w_valid, w_sat;
  logic signed [WIDTH-1:0] w_a, w_b, w_res;

`ifdef DENORM_ZERO_BYPASS_EN
  logic [WIDTH-1:0] w_len_mag;
  logic             w_small;
  assign w_len_mag = length[WIDTH-1] ? WIDTH'(-length) : WIDTH'(length);
  assign w_small   = w_len_mag < WIDTH'(EPS);
`endif

  // x is loaded straight from the ports on acceptance; y and z from the captured copies.
  always_comb begin
    w_load = 1'b0;
    w_a    = nx;
    w_b    = r_len;
    if (r_state == IDLE) begin
      w_load = start;
      w_b    = length;
    end else if (r_state == FIN && r_comp != COMP_Z) begin
      w_load = 1'b1;
      w_a    = (r_comp == COMP_X) ? r_ny : r_nz;
    end
  end

  seq_fix_mult #(
    .WIDTH      (WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_last   (w_last),
    .o_valid  (w_valid),
    .o_result (w_res),
    .o_sat    (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_comp   <= COMP_X;
      r_ny     <= '0;
      r_nz     <= '0;
      r_len    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_ny     <= ny;
          r_nz     <= nz;
          r_len    <= length;
          r_comp   <= COMP_X;
          r_sticky <= 1'b0;
`ifdef DENORM_ZERO_BYPASS_EN
          if (w_small) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else
`endif
          begin
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: if (w_last) r_state <= FIN;
        FIN: if (w_valid) begin
          case (r_comp)
            COMP_X:  r_x <= w_res;
            COMP_Y:  r_y <= w_res;
            default: r_z <= w_res;
          endcase
          r_sticky <= r_sticky | w_sat;
          if (r_comp != COMP_Z) begin
            r_comp  <= (r_comp == COMP_X) ? COMP_Y : COMP_Z;
            r_state <= MUL;
          end else begin
            r_ovf   <= r_sticky | w_sat;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign x        = r_x;
  assign y        = r_y;
  assign z        = r_z;
  assign overflow = r_ovf;

endmodule
